// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory handshakes, retire counter.
// Optional memory-wait timeout enabled by defining MEM_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int RET_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_err,
  output logic [RET_W-1:0] retire_cnt,
  output logic [2:0]       fsm_state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_BEQ = 4'hb;
  localparam logic [3:0] OP_BNE = 4'hc;
  localparam logic [3:0] OP_JMP = 4'hd;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [3:0] op_q;
  logic       retire;
  logic       timeout;
  logic       is_mem_op;
  logic       is_branch;

  // The timeout counter needs at least one bit of wait state to be meaningful.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_unsupported
  end

  assign fsm_state = state;
  assign is_mem_op = (op_q == OP_LD) || (op_q == OP_ST);
  assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_JMP);

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              acked;

  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign acked   = (state == S_FETCH) ? imem_ready : dmem_ready;
  // Ready in the final wait cycle still wins over the timeout.
  assign timeout = waiting && !acked && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state != next_state) || timeout) begin
      wait_cnt <= '0;
    end else if (waiting && !acked) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    bus_err    = timeout;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if ((opcode == 4'ha) || (opcode == 4'he) || (opcode == 4'hf)) begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_op) begin
          alu_op     = 2'b10;
          alu_src    = 1'b1;
          next_state = S_MEM;
        end else if (is_branch) begin
          alu_op     = 2'b01;
          retire     = 1'b1;
          next_state = S_FETCH;
          case (op_q)
            OP_BEQ:  pc_load = alu_zero;
            OP_BNE:  pc_load = !alu_zero;
            default: pc_load = 1'b1;
          endcase
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        alu_op   = 2'b10;
        alu_src  = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_ST);
        if (dmem_ready) begin
          if (op_q == OP_ST) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (timeout) begin
          next_state = S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LD);
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset aborts the instruction: nothing escapes in the reset cycle.
    if (rst) begin
      retire     = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      op_q       <= 4'h0;
      retire_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
      if (retire) begin
        retire_cnt <= retire_cnt + RET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/strobe checks and retire counting,
// with a narrow-counter second instance to exercise counter wrap.
module tb_multicycle_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  localparam logic [2:0] S_F = 3'd0;
  localparam logic [2:0] S_D = 3'd1;
  localparam logic [2:0] S_E = 3'd2;
  localparam logic [2:0] S_M = 3'd3;
  localparam logic [2:0] S_W = 3'd4;

  // {imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, alu_op[1:0], alu_src, reg_write, mem_to_reg, illegal, bus_err}
  localparam logic [12:0] V_IDLE   = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] V_F_RDY  = 13'b1_0_0_1_1_0_00_0_0_0_0_0;
  localparam logic [12:0] V_F_WAIT = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] V_ILL    = 13'b0_0_0_0_0_0_00_0_0_0_1_0;
  localparam logic [12:0] V_E_LS   = 13'b0_0_0_0_0_0_10_1_0_0_0_0;
  localparam logic [12:0] V_M_LD   = 13'b0_1_0_0_0_0_10_1_0_0_0_0;
  localparam logic [12:0] V_M_ST   = 13'b0_1_1_0_0_0_10_1_0_0_0_0;
  localparam logic [12:0] V_WB     = 13'b0_0_0_0_0_0_00_0_1_0_0_0;
  localparam logic [12:0] V_WB_LD  = 13'b0_0_0_0_0_0_00_0_1_1_0_0;
  localparam logic [12:0] V_BR_T   = 13'b0_0_0_0_0_1_01_0_0_0_0_0;
  localparam logic [12:0] V_BR_N   = 13'b0_0_0_0_0_0_01_0_0_0_0_0;
  localparam logic [12:0] V_M_BERR = 13'b0_1_0_0_0_0_10_1_0_0_0_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic        alu_zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load;
  logic [1:0]  alu_op;
  logic        alu_src, reg_write, mem_to_reg, illegal, bus_err;
  logic [15:0] retire_cnt;
  logic [2:0]  fsm_state;
  logic [12:0] outs;

  logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_load, w_pc_inc, w_pc_load;
  logic [1:0]  w_alu_op;
  logic        w_alu_src, w_reg_write, w_mem_to_reg, w_illegal, w_bus_err;
  logic [3:0]  w_retire_cnt;
  logic [2:0]  w_fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign outs = {imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load,
                 alu_op, alu_src, reg_write, mem_to_reg, illegal, bus_err};

  multicycle_ctrl #(.RET_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err),
    .retire_cnt(retire_cnt), .fsm_state(fsm_state)
  );

  multicycle_ctrl #(.RET_W(4), .TIMEOUT_CYCLES(TO)) u_wrap (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(w_imem_req), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
    .ir_load(w_ir_load), .pc_inc(w_pc_inc), .pc_load(w_pc_load),
    .alu_op(w_alu_op), .alu_src(w_alu_src), .reg_write(w_reg_write),
    .mem_to_reg(w_mem_to_reg), .illegal(w_illegal), .bus_err(w_bus_err),
    .retire_cnt(w_retire_cnt), .fsm_state(w_fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; check state and strobes mid-cycle, then step to just after the next edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] v);
    @(negedge clk);
    chk({tag, "/state"}, 32'(fsm_state), 32'(st));
    chk({tag, "/outs"}, 32'(outs), 32'(v));
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input string tag, input logic [3:0] op, input logic z, input logic [12:0] ev);
    opcode     = op;
    alu_zero   = z;
    imem_ready = 1'b1;
    cyc({tag, "_f"}, S_F, V_F_RDY);
    imem_ready = 1'b0;
    cyc({tag, "_d"}, S_D, V_IDLE);
    cyc({tag, "_e"}, S_E, ev);
  endtask

  initial begin
    rst        = 1'b1;
    opcode     = 4'h0;
    alu_zero   = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", S_F, V_IDLE);
    chk("reset/retire", 32'(retire_cnt), 32'd0);
    rst        = 1'b0;
    dmem_ready = 1'b0;

    // ADD, zero-wait
    opcode = 4'h2;
    cyc("add_f", S_F, V_F_RDY);
    cyc("add_d", S_D, V_IDLE);
    chk("add_d/retire", 32'(retire_cnt), 32'd0);
    cyc("add_e", S_E, V_IDLE);
    cyc("add_wb", S_W, V_WB);
    chk("add/retire", 32'(retire_cnt), 32'd1);

    // LD, data memory acks after 3 wait cycles; early ready in D/E must not matter
    opcode     = 4'h0;
    dmem_ready = 1'b1;
    cyc("ld_f", S_F, V_F_RDY);
    cyc("ld_d", S_D, V_IDLE);
    cyc("ld_e", S_E, V_E_LS);
    dmem_ready = 1'b0;
    repeat (3) cyc("ld_mwait", S_M, V_M_LD);
    dmem_ready = 1'b1;
    cyc("ld_mack", S_M, V_M_LD);
    dmem_ready = 1'b0;
    chk("ld_mack/retire", 32'(retire_cnt), 32'd1);
    cyc("ld_wb", S_W, V_WB_LD);
    chk("ld/retire", 32'(retire_cnt), 32'd2);

    // ST, same wait, retires on the ack
    opcode = 4'h1;
    cyc("st_f", S_F, V_F_RDY);
    cyc("st_d", S_D, V_IDLE);
    cyc("st_e", S_E, V_E_LS);
    repeat (3) cyc("st_mwait", S_M, V_M_ST);
    dmem_ready = 1'b1;
    cyc("st_mack", S_M, V_M_ST);
    dmem_ready = 1'b0;
    chk("st/retire", 32'(retire_cnt), 32'd3);
    imem_ready = 1'b0;
    cyc("st_next", S_F, V_F_WAIT);

    // Branches
    branch("beq_z1", 4'hb, 1'b1, V_BR_T);
    chk("beq_z1/retire", 32'(retire_cnt), 32'd4);
    branch("bne_z1", 4'hc, 1'b1, V_BR_N);
    chk("bne_z1/retire", 32'(retire_cnt), 32'd5);
    branch("bne_z0", 4'hc, 1'b0, V_BR_T);
    branch("beq_z0", 4'hb, 1'b0, V_BR_N);
    branch("jmp", 4'hd, 1'b0, V_BR_T);
    chk("jmp/retire", 32'(retire_cnt), 32'd8);

    // Illegal opcode 1110
    opcode     = 4'he;
    imem_ready = 1'b1;
    cyc("ill_f", S_F, V_F_RDY);
    imem_ready = 1'b0;
    cyc("ill_d", S_D, V_ILL);
    cyc("ill_next", S_F, V_F_WAIT);
    chk("ill/retire", 32'(retire_cnt), 32'd8);

    // SUB after a fetch wait
    opcode     = 4'h3;
    imem_ready = 1'b1;
    cyc("sub_f", S_F, V_F_RDY);
    imem_ready = 1'b0;
    cyc("sub_d", S_D, V_IDLE);
    cyc("sub_e", S_E, V_IDLE);
    cyc("sub_wb", S_W, V_WB);
    chk("sub/retire", 32'(retire_cnt), 32'd9);
    chk("sub/retire_w", 32'(w_retire_cnt), 32'd9);

    // LD with data memory never acking
    opcode     = 4'h0;
    imem_ready = 1'b1;
    cyc("ldto_f", S_F, V_F_RDY);
    imem_ready = 1'b0;
    cyc("ldto_d", S_D, V_IDLE);
    cyc("ldto_e", S_E, V_E_LS);
`ifdef MEM_TIMEOUT_EN
    repeat (3) cyc("ldto_mwait", S_M, V_M_LD);
    cyc("ldto_berr", S_M, V_M_BERR);
    cyc("ldto_next", S_F, V_F_WAIT);
    chk("ldto/retire", 32'(retire_cnt), 32'd9);
`else
    repeat (20) cyc("ldto_mwait", S_M, V_M_LD);
    dmem_ready = 1'b1;
    cyc("ldto_mack", S_M, V_M_LD);
    dmem_ready = 1'b0;
    cyc("ldto_wb", S_W, V_WB_LD);
    chk("ldto/retire", 32'(retire_cnt), 32'd10);
`endif

    // Reset in MEM of a ST aborts it
    opcode     = 4'h1;
    imem_ready = 1'b1;
    cyc("strst_f", S_F, V_F_RDY);
    imem_ready = 1'b0;
    cyc("strst_d", S_D, V_IDLE);
    cyc("strst_e", S_E, V_E_LS);
    cyc("strst_m", S_M, V_M_ST);
    rst        = 1'b1;
    dmem_ready = 1'b1;
    cyc("strst_rst", S_M, V_IDLE);
    rst        = 1'b0;
    dmem_ready = 1'b0;
    chk("strst/retire", 32'(retire_cnt), 32'd0);
    chk("strst/retire_w", 32'(w_retire_cnt), 32'd0);
    cyc("strst_next", S_F, V_F_WAIT);

    // Sixteen JMPs: the 4-bit counter wraps 15 -> 0
    for (int i = 1; i <= 16; i++) begin
      branch("jmpw", 4'hd, i[0], V_BR_T);
      chk("jmpw/retire", 32'(retire_cnt), 32'(i));
      chk("jmpw/retire_w", 32'(w_retire_cnt), 32'(i % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
